// File: rtl/qspi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qspi_pkg                                                             |
// | Shared QSPI controller definitions: requester/owner encoding,        |
// | arbiter state encoding, transfer-config bundle width and field       |
// | offsets used by cmd_engine, xip_engine, qspi_fsm and the arbiter.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package qspi_pkg;

  // Bus owner as seen on owner_o
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CMD  = 2'b01,
    OWN_XIP  = 2'b10
  } owner_t;

  // Arbiter state machine
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_START   = 2'b01,
    ST_BUSY    = 2'b10,
    ST_RELEASE = 2'b11
  } arb_state_t;

  // Packed transfer-config bundle
  localparam int QSPI_CFG_W        = 128;
  localparam int CFG_OPCODE_LSB    = 0;   // 8 bits
  localparam int CFG_ADDR_LSB      = 8;   // 32 bits
  localparam int CFG_LEN_LSB       = 40;  // 32 bits
  localparam int CFG_LANES_LSB     = 72;  // 2 bits
  localparam int CFG_DUMMY_LSB     = 74;  // 5 bits
  localparam int CFG_MODE_LSB      = 79;  // 8 bits
  localparam int CFG_CLKDIV_LSB    = 87;  // 8 bits
  localparam int CFG_CPOL_BIT      = 95;
  localparam int CFG_CPHA_BIT      = 96;
  localparam int CFG_DIR_BIT       = 97;
  localparam int CFG_CS_AUTO_BIT   = 98;
  localparam int CFG_CONT_READ_BIT = 99;

endpackage
`default_nettype wire

// File: rtl/qspi_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qspi_wdog                                                            |
// | Transfer watchdog counter. Cleared by clr, counts while en, raises   |
// | expired when the count equals TIMEOUT_CYCLES-1. TIMEOUT_CYCLES=0     |
// | disables expiry.                                                     |
// | Ports: clk, resetn (async active-low), clr, en -> expired            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module qspi_wdog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/qspi_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | qspi_bus_arbiter                                                     |
// | Round-robin arbiter between cmd_engine and xip_engine for the shared |
// | qspi_fsm. Muxes owner config/TX path, routes done back to the owner, |
// | aborts hung transfers via the watchdog.                              |
// | Ports: cmd_*/xip_* requester side (req, cfg, tx data/empty in;       |
// |        gnt, done, err, tx_ren out), xip_cmd_busy_o, fsm_* FSM side,  |
// |        owner_o (00 none, 01 cmd, 10 xip).                            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module qspi_bus_arbiter
  import qspi_pkg::*;
#(
  parameter int CFG_W          = QSPI_CFG_W,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_req_i,
  input  logic             xip_req_i,
  input  logic [CFG_W-1:0] cmd_cfg_i,
  input  logic [CFG_W-1:0] xip_cfg_i,
  input  logic [31:0]      cmd_tx_data_i,
  input  logic [31:0]      xip_tx_data_i,
  input  logic             cmd_tx_empty_i,
  input  logic             xip_tx_empty_i,
  output logic             cmd_gnt_o,
  output logic             xip_gnt_o,
  output logic             cmd_done_o,
  output logic             xip_done_o,
  output logic             cmd_err_o,
  output logic             xip_err_o,
  output logic             cmd_tx_ren_o,
  output logic             xip_tx_ren_o,
  output logic             xip_cmd_busy_o,
  output logic             fsm_start_o,
  output logic [CFG_W-1:0] fsm_cfg_o,
  output logic [31:0]      fsm_tx_data_o,
  output logic             fsm_tx_empty_o,
  input  logic             fsm_tx_ren_i,
  input  logic             fsm_done_i,
  output logic             fsm_abort_o,
  output logic [1:0]       owner_o
);

  arb_state_t       r_state;
  owner_t           r_owner;
  owner_t           r_last;
  logic             r_start;
  logic             r_cmd_done, r_xip_done;
  logic             r_cmd_err, r_xip_err;
  logic [CFG_W-1:0] r_cfg;

  owner_t           w_winner;
  logic [CFG_W-1:0] w_owner_cfg;
  logic             w_busy;
  logic             w_expired;
  logic             w_timeout;
  logic             w_finish;

  // Single request wins outright; on a tie the requester that did not
  // own the bus last time goes first.
  always_comb begin
    w_winner = OWN_NONE;
    if (cmd_req_i && xip_req_i) begin
      w_winner = (r_last == OWN_CMD) ? OWN_XIP : OWN_CMD;
    end else if (cmd_req_i) begin
      w_winner = OWN_CMD;
    end else if (xip_req_i) begin
      w_winner = OWN_XIP;
    end
  end

  assign w_owner_cfg = (r_owner == OWN_XIP) ? xip_cfg_i : cmd_cfg_i;
  assign w_busy      = (r_state == ST_BUSY);
  // A done landing in the expiry cycle takes priority over the timeout,
  // which is why the abort is qualified by fsm_done_i in the same cycle.
  assign w_timeout   = w_busy && w_expired && !fsm_done_i;
  assign w_finish    = w_busy && (fsm_done_i || w_expired);

  qspi_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .resetn (resetn),
    .clr    (r_state == ST_START),
    .en     (w_busy),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_NONE;
      r_last     <= OWN_XIP;
      r_start    <= 1'b0;
      r_cmd_done <= 1'b0;
      r_xip_done <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_xip_err  <= 1'b0;
      r_cfg      <= '0;
    end else begin
      r_start    <= 1'b0;
      r_cmd_done <= 1'b0;
      r_xip_done <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_xip_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_winner != OWN_NONE) begin
            r_state <= ST_START;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_start <= 1'b1;
            r_cfg   <= (w_winner == OWN_CMD) ? cmd_cfg_i : xip_cfg_i;
          end
        end
        ST_START: begin
          r_state <= ST_BUSY;
          r_cfg   <= w_owner_cfg;
        end
        ST_BUSY: begin
          r_cfg <= w_owner_cfg;
          if (w_finish) begin
            r_state    <= ST_RELEASE;
            r_cmd_done <= (r_owner == OWN_CMD);
            r_xip_done <= (r_owner == OWN_XIP);
            r_cmd_err  <= (r_owner == OWN_CMD) && w_timeout;
            r_xip_err  <= (r_owner == OWN_XIP) && w_timeout;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_cfg   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_cfg   <= '0;
        end
      endcase
    end
  end

  assign cmd_gnt_o   = (r_owner == OWN_CMD);
  assign xip_gnt_o   = (r_owner == OWN_XIP);
  assign owner_o     = r_owner;
  assign fsm_start_o = r_start;
  assign fsm_cfg_o   = r_cfg;
  assign cmd_done_o  = r_cmd_done;
  assign xip_done_o  = r_xip_done;
  assign cmd_err_o   = r_cmd_err;
  assign xip_err_o   = r_xip_err;
  assign fsm_abort_o = w_timeout;

  // The TX path is a FIFO handshake: data/empty and pops pass straight
  // through under the registered owner select so pop and data stay aligned.
  assign cmd_tx_ren_o   = w_busy && (r_owner == OWN_CMD) && fsm_tx_ren_i;
  assign xip_tx_ren_o   = w_busy && (r_owner == OWN_XIP) && fsm_tx_ren_i;
  assign fsm_tx_data_o  = (r_owner == OWN_CMD) ? cmd_tx_data_i :
                          (r_owner == OWN_XIP) ? xip_tx_data_i : 32'h0;
  assign fsm_tx_empty_o = (r_owner == OWN_CMD) ? cmd_tx_empty_i :
                          (r_owner == OWN_XIP) ? xip_tx_empty_i : 1'b1;

  // Combinational so the XIP engine sees a command in its request cycle.
  assign xip_cmd_busy_o = cmd_req_i || cmd_gnt_o;

endmodule
`default_nettype wire

// File: tb/tb_qspi_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_qspi_bus_arbiter                                                  |
// | Self-checking bench for qspi_bus_arbiter: table of transfers with    |
// | expected owner/err, scoreboard queues for grants and done pulses,    |
// | hand-written reset and idle-input sequences.                         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_qspi_bus_arbiter;

  localparam int TMO   = 16;
  localparam int CFG_W = 128;

  localparam logic [1:0] O_NONE = 2'b00;
  localparam logic [1:0] O_CMD  = 2'b01;
  localparam logic [1:0] O_XIP  = 2'b10;

  localparam logic [CFG_W-1:0] CMD_CFG = 128'h0000_000C_1111_2222_3333_4444_5555_9F03;
  localparam logic [CFG_W-1:0] XIP_CFG = 128'h0000_000A_DEAD_BEEF_0000_0100_8000_00EB;
  localparam logic [31:0]      CMD_TXD = 32'h0BAD_C0DE;
  localparam logic [31:0]      XIP_TXD = 32'hA5A5_1234;

  logic             clk = 1'b0;
  logic             resetn;
  logic             cmd_req, xip_req;
  logic             cmd_gnt_o, xip_gnt_o, cmd_done_o, xip_done_o;
  logic             cmd_err_o, xip_err_o, cmd_tx_ren_o, xip_tx_ren_o;
  logic             xip_cmd_busy_o, fsm_start_o, fsm_tx_empty_o, fsm_abort_o;
  logic [CFG_W-1:0] fsm_cfg_o;
  logic [31:0]      fsm_tx_data_o;
  logic [1:0]       owner_o;
  logic             fsm_tx_ren, fsm_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [1:0] exp_gnt_q[$];
  logic [2:0] exp_done_q[$];   // {owner, err}

  typedef struct {
    bit         cmd_req;
    bit         xip_req;
    int         dly;        // done at START+dly; -1 means never (timeout)
    int         pops;       // TX pops on the first BUSY cycles
    logic [1:0] own;        // expected owner
    bit         err;        // expected timeout error
    int         raise_cmd;  // raise cmd_req at START+raise_cmd (0 = no)
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  qspi_bus_arbiter #(
    .CFG_W(CFG_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_req_i     (cmd_req),
    .xip_req_i     (xip_req),
    .cmd_cfg_i     (CMD_CFG),
    .xip_cfg_i     (XIP_CFG),
    .cmd_tx_data_i (CMD_TXD),
    .xip_tx_data_i (XIP_TXD),
    .cmd_tx_empty_i(1'b0),
    .xip_tx_empty_i(1'b1),
    .cmd_gnt_o     (cmd_gnt_o),
    .xip_gnt_o     (xip_gnt_o),
    .cmd_done_o    (cmd_done_o),
    .xip_done_o    (xip_done_o),
    .cmd_err_o     (cmd_err_o),
    .xip_err_o     (xip_err_o),
    .cmd_tx_ren_o  (cmd_tx_ren_o),
    .xip_tx_ren_o  (xip_tx_ren_o),
    .xip_cmd_busy_o(xip_cmd_busy_o),
    .fsm_start_o   (fsm_start_o),
    .fsm_cfg_o     (fsm_cfg_o),
    .fsm_tx_data_o (fsm_tx_data_o),
    .fsm_tx_empty_o(fsm_tx_empty_o),
    .fsm_tx_ren_i  (fsm_tx_ren),
    .fsm_done_i    (fsm_done),
    .fsm_abort_o   (fsm_abort_o),
    .owner_o       (owner_o)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: grant and done pulses are matched against expectations
  // queued by the driver when the request was raised.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (fsm_start_o) begin
        if (exp_gnt_q.size() == 0) begin
          chk("unexpected_start", {127'b0, fsm_start_o}, 128'd0);
        end else begin
          logic [1:0] e;
          e = exp_gnt_q.pop_front();
          chk("grant", {cmd_gnt_o, xip_gnt_o, owner_o}, {e == O_CMD, e == O_XIP, e});
        end
      end
      if (cmd_done_o || xip_done_o) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", {cmd_done_o, xip_done_o}, 2'b00);
        end else begin
          logic [2:0] d;
          d = exp_done_q.pop_front();
          chk("done_err", {cmd_done_o, xip_done_o, cmd_err_o, xip_err_o},
              {d[2:1] == O_CMD, d[2:1] == O_XIP,
               d[0] && (d[2:1] == O_CMD), d[0] && (d[2:1] == O_XIP)});
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int last_k;
    int n_cr;
    int n_xr;
    chk("idle_owner", owner_o, O_NONE);
    cmd_req = v.cmd_req;
    xip_req = v.xip_req;
    exp_gnt_q.push_back(v.own);
    exp_done_q.push_back({v.own, v.err});
    tick;
    chk("start_pulse", fsm_start_o, 1'b1);
    chk("start_cfg", fsm_cfg_o, (v.own == O_CMD) ? CMD_CFG : XIP_CFG);
    last_k = (v.dly >= 0) ? v.dly : TMO;
    n_cr = 0;
    n_xr = 0;
    for (int k = 1; k <= last_k; k++) begin
      tick;
      fsm_tx_ren = (k <= v.pops);
      fsm_done   = (k == v.dly);
      if (k == v.raise_cmd) cmd_req = 1'b1;
      #1;
      n_cr += int'(cmd_tx_ren_o);
      n_xr += int'(xip_tx_ren_o);
      if (k == 1) begin
        chk("tx_mux", {fsm_tx_data_o, fsm_tx_empty_o},
            (v.own == O_CMD) ? {CMD_TXD, 1'b0} : {XIP_TXD, 1'b1});
      end
      if (k == v.raise_cmd) chk("cmd_busy", xip_cmd_busy_o, 1'b1);
      if (k == TMO) chk("abort", fsm_abort_o, v.err);
    end
    tick;
    fsm_tx_ren = 1'b0;
    fsm_done   = 1'b0;
    chk("done_latency", {cmd_done_o, xip_done_o}, {v.own == O_CMD, v.own == O_XIP});
    if (v.own == O_CMD) cmd_req = 1'b0;
    else xip_req = 1'b0;
    chk("cmd_ren_count", n_cr, (v.own == O_CMD) ? v.pops : 0);
    chk("xip_ren_count", n_xr, (v.own == O_XIP) ? v.pops : 0);
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n_late_done;

    //            cmd  xip  dly pops own    err raise
    tbl[0]  = '{1'b1, 1'b1,  5, 0, O_CMD, 1'b0, 0};
    tbl[1]  = '{1'b0, 1'b1,  5, 0, O_XIP, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b1,  4, 0, O_CMD, 1'b0, 0};
    tbl[3]  = '{1'b0, 1'b1,  4, 0, O_XIP, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b1,  3, 0, O_CMD, 1'b0, 0};
    tbl[5]  = '{1'b0, 1'b1,  3, 0, O_XIP, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b1,  6, 0, O_CMD, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1,  6, 0, O_XIP, 1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0, 14, 2, O_CMD, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b1, 10, 3, O_XIP, 1'b0, 0};  // last was CMD
    tbl[10] = '{1'b1, 1'b0, -1, 0, O_CMD, 1'b1, 0};  // watchdog timeout
    tbl[11] = '{1'b0, 1'b1, TMO, 0, O_XIP, 1'b0, 5}; // done at expiry
    tbl[12] = '{1'b1, 1'b0,  2, 0, O_CMD, 1'b0, 0};  // pending cmd served

    resetn     = 1'b0;
    cmd_req    = 1'b0;
    xip_req    = 1'b0;
    fsm_tx_ren = 1'b0;
    fsm_done   = 1'b0;
    tick;
    tick;
    chk("rst_ctrl", {cmd_gnt_o, xip_gnt_o, owner_o, fsm_start_o, fsm_abort_o,
                     cmd_done_o, xip_done_o, cmd_err_o, xip_err_o, xip_cmd_busy_o}, 11'd0);
    chk("rst_tx", {fsm_tx_data_o, fsm_tx_empty_o, cmd_tx_ren_o, xip_tx_ren_o}, {32'h0, 1'b1, 2'b00});
    chk("rst_cfg", fsm_cfg_o, 128'd0);
    tick;
    resetn = 1'b1;
    tick;

    // FSM strobes while idle must not leak to either requester.
    fsm_done   = 1'b1;
    fsm_tx_ren = 1'b1;
    #1;
    chk("idle_ren", {cmd_tx_ren_o, xip_tx_ren_o, fsm_abort_o}, 3'b000);
    tick;
    fsm_done   = 1'b0;
    fsm_tx_ren = 1'b0;
    chk("idle_ignore", {owner_o, fsm_start_o, cmd_done_o, xip_done_o}, 5'd0);
    tick;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Asynchronous reset in the middle of a CMD transfer.
    cmd_req = 1'b1;
    exp_gnt_q.push_back(O_CMD);
    tick;
    tick;
    tick;
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_ctrl", {cmd_gnt_o, xip_gnt_o, owner_o, fsm_start_o, fsm_abort_o,
                           cmd_done_o, xip_done_o}, 8'd0);
    chk("async_rst_tx", {fsm_tx_empty_o, fsm_cfg_o}, {1'b1, 128'd0});
    cmd_req = 1'b0;
    tick;
    tick;
    resetn = 1'b1;
    n_late_done = 0;
    for (int k = 0; k < 25; k++) begin
      tick;
      n_late_done += int'(cmd_done_o) + int'(xip_done_o) + int'(owner_o != O_NONE);
    end
    chk("no_done_after_reset", n_late_done, 0);
    chk("scoreboard_drained", exp_gnt_q.size() + exp_done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
